sigmoid: RTL and testbench
==========================

SIGMOID -- requirements
Module: sigmoid

Interface
REQ-001 SHALL have no parameters; the only build-time option is the macro in Configuration.
REQ-002 SHALL have ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- zed  input  8  signed two's-complement Q4.4 operand, x = signed(zed)/16, range -8.0..+7.9375
- in_valid  input  1  zed is valid this cycle
- activation  output  8  unsigned Q0.8 sigmoid result, value = activation/256
- out_valid  output  1  activation holds a freshly computed result
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL compute for each zed the value A(zed) = min(255, floor(256/(1+exp(-x)) + 0.5)), with x = signed(zed)/16.
REQ-005 SHALL realise A as a 256-entry constant table indexed by zed; all entries are fixed at elaboration; there is no run-time arithmetic on exp.
REQ-006 SHALL clamp: zed=0x80 (x=-8.0) gives 0; zed=0x7F (x=+7.9375) gives 255; no table entry exceeds 255.
REQ-007 SHALL give A(0x00)=128, A(0x10)=187, A(0xF0)=69, A(0x20)=225, A(0xE0)=31.
REQ-008 SHALL make A monotonically non-decreasing in signed(zed).
REQ-009 SHALL register the output, as follows:
- on a rising clk edge with in_valid=1, load activation with A(zed) and set out_valid=1
- on a rising clk edge with in_valid=0, hold activation unchanged and set out_valid=0
REQ-010 SHALL have a latency of 1 cycle from sampling zed to activation/out_valid (macro undefined); throughput is one result per cycle, with no stall or backpressure.
REQ-011 SHALL treat back-to-back valid inputs independently, so each cycle's result depends only on that cycle's zed.
REQ-012 SHALL NOT let activation change combinationally with zed.

Reset
REQ-013 SHALL force activation=0x00 and out_valid=0 immediately while rst_n=0, independent of clk.
REQ-014 SHALL, when rst_n is asserted mid-stream, discard any in-flight result; after deassertion the first result appears one latency after the next in_valid=1 cycle.
REQ-015 SHALL hold reset state while rst_n=0 regardless of in_valid or zed.

Configuration
REQ-016 SHALL support the macro SIGMOID_INPUT_REG_EN.
- Defined: adds an input register stage for zed and in_valid, reset to 0x00/0 on rst_n=0. Latency becomes 2 cycles, throughput stays one per cycle, and results are identical to REQ-004.
- Undefined: single-stage design per REQ-009/REQ-010.

Verification
REQ-017 Reset check: assert rst_n=0 mid-operation with activation=187 -> activation=0x00 and out_valid=0 immediately, without waiting for a clk edge.
REQ-018 Exhaustive sweep: zed=0x00..0xFF, one per cycle with in_valid=1 -> each activation equals the A(zed) model one latency later; 0x00->128, 0x10->187, 0xF0->69, 0x7F->255, 0x80->0.
REQ-019 Hold check: in_valid=1 with zed=0x10, then in_valid=0 with zed=0xF0 for 3 cycles -> activation stays 187 and out_valid=0 after the first result cycle.
REQ-020 Monotonicity check: sweep signed zed -128..+127 -> no result is smaller than its predecessor.
REQ-021 Latency check: with SIGMOID_INPUT_REG_EN defined, in_valid pulse with zed=0x20 -> out_valid=1 and activation=225 exactly 2 cycles later (1 cycle when undefined).

Source files
------------

// File: rtl/sigmoid.sv
// sigmoid: Q4.4 signed operand -> Q0.8 logistic activation via a constant lookup table.
// Optional macro SIGMOID_INPUT_REG_EN inserts an input register stage (latency 2 instead of 1).
module sigmoid (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zed,
  input  logic       in_valid,
  output logic [7:0] activation,
  output logic       out_valid
);

  // Indexed directly by the raw zed byte, so 0x80..0xFF hold the negative operands.
  localparam logic [7:0] LUT [256] = '{
    8'd128, 8'd132, 8'd136, 8'd140, 8'd144, 8'd148, 8'd152, 8'd156,
    8'd159, 8'd163, 8'd167, 8'd170, 8'd174, 8'd177, 8'd181, 8'd184,
    8'd187, 8'd190, 8'd193, 8'd196, 8'd199, 8'd202, 8'd204, 8'd207,
    8'd209, 8'd212, 8'd214, 8'd216, 8'd218, 8'd220, 8'd222, 8'd224,
    8'd225, 8'd227, 8'd229, 8'd230, 8'd232, 8'd233, 8'd234, 8'd235,
    8'd237, 8'd238, 8'd239, 8'd240, 8'd241, 8'd241, 8'd242, 8'd243,
    8'd244, 8'd245, 8'd245, 8'd246, 8'd246, 8'd247, 8'd248, 8'd248,
    8'd248, 8'd249, 8'd249, 8'd250, 8'd250, 8'd250, 8'd251, 8'd251,
    8'd251, 8'd252, 8'd252, 8'd252, 8'd252, 8'd253, 8'd253, 8'd253,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254,
    8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,
    8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,
    8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,
    8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd1,   8'd1,   8'd1,
    8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,
    8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd2,   8'd2,
    8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd3,
    8'd3,   8'd3,   8'd3,   8'd3,   8'd4,   8'd4,   8'd4,   8'd4,
    8'd5,   8'd5,   8'd5,   8'd6,   8'd6,   8'd6,   8'd7,   8'd7,
    8'd8,   8'd8,   8'd8,   8'd9,   8'd10,  8'd10,  8'd11,  8'd11,
    8'd12,  8'd13,  8'd14,  8'd15,  8'd15,  8'd16,  8'd17,  8'd18,
    8'd19,  8'd21,  8'd22,  8'd23,  8'd24,  8'd26,  8'd27,  8'd29,
    8'd31,  8'd32,  8'd34,  8'd36,  8'd38,  8'd40,  8'd42,  8'd44,
    8'd47,  8'd49,  8'd52,  8'd54,  8'd57,  8'd60,  8'd63,  8'd66,
    8'd69,  8'd72,  8'd75,  8'd79,  8'd82,  8'd86,  8'd89,  8'd93,
    8'd97,  8'd100, 8'd104, 8'd108, 8'd112, 8'd116, 8'd120, 8'd124
  };

  logic [7:0] lookupZed;
  logic       lookupValid;

`ifdef SIGMOID_INPUT_REG_EN
  logic [7:0] zed_q;
  logic       inValid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zed_q     <= 8'h00;
      inValid_q <= 1'b0;
    end else begin
      zed_q     <= zed;
      inValid_q <= in_valid;
    end
  end

  assign lookupZed   = zed_q;
  assign lookupValid = inValid_q;
`else
  assign lookupZed   = zed;
  assign lookupValid = in_valid;
`endif

  logic [7:0] activation_d, activation_q;
  logic       outValid_d, outValid_q;

  // Idle cycles keep the last result but drop the valid flag.
  always_comb begin
    activation_d = activation_q;
    outValid_d   = lookupValid;
    if (lookupValid) begin
      activation_d = LUT[lookupZed];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      activation_q <= 8'h00;
      outValid_q   <= 1'b0;
    end else begin
      activation_q <= activation_d;
      outValid_q   <= outValid_d;
    end
  end

  assign activation = activation_q;
  assign out_valid  = outValid_q;

endmodule

// File: tb/tb_sigmoid.sv
// tb_sigmoid: directed and swept checks of the sigmoid lookup, reset, hold and latency behaviour.
// Latency expectation follows SIGMOID_INPUT_REG_EN (2 when defined, 1 otherwise).
module tb_sigmoid;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] zed = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] activation;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

`ifdef SIGMOID_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  sigmoid dut (
    .clk(clk),
    .rst_n(rst_n),
    .zed(zed),
    .in_valid(in_valid),
    .activation(activation),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Independent real-valued reference for the rounded, clamped logistic.
  function automatic logic [7:0] refModel(input logic [7:0] z);
    real x, v;
    int  r;
    x = real'($signed(z)) / 16.0;
    v = 256.0 / (1.0 + $exp(-x));
    r = $rtoi(v + 0.5);
    if (r > 255) r = 255;
    return 8'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] z);
    in_valid = v;
    zed      = z;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h7F);
    repeat (3) tick();
    checks++;
    if (activation !== 8'h00) begin errors++; $display("[TB] FAIL reset_act: got %0d expected 0", activation); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h10);
    repeat (LAT) tick();
    checks++;
    if (activation !== 8'd187 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_result: got %0d/%b expected 187/1", activation, out_valid);
    end
    // Mid-cycle assertion, well away from any clock edge.
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (activation !== 8'h00 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset: got %0d/%b expected 0/0", activation, out_valid);
    end
    repeat (2) tick();
    checks++;
    if (activation !== 8'h00 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_hold: got %0d/%b expected 0/0", activation, out_valid);
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00);
    repeat (LAT) tick();
    checks++;
    if (activation !== 8'h00 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL discard_inflight: got %0d/%b expected 0/0", activation, out_valid);
    end
    applyStimulus(1'b1, 8'hE0);
    tick();
    applyStimulus(1'b0, 8'h00);
    repeat (LAT - 1) tick();
    checks++;
    if (activation !== 8'd31 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL first_after_reset: got %0d/%b expected 31/1", activation, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [7:0] dz [12] = '{8'h00, 8'h10, 8'hF0, 8'h20, 8'hE0, 8'h7F,
                            8'h80, 8'h01, 8'hFF, 8'h2D, 8'h38, 8'hC8};
    logic [7:0] da [12] = '{8'd128, 8'd187, 8'd69, 8'd225, 8'd31, 8'd255,
                            8'd0,   8'd132, 8'd124, 8'd241, 8'd248, 8'd8};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, dz[i]);
      tick();
      applyStimulus(1'b0, 8'h00);
      repeat (LAT - 1) tick();
      checks++;
      if (activation !== da[i] || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL directed_%02h: got %0d/%b expected %0d/1", dz[i], activation, out_valid, da[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prevAct;
    logic [7:0] expAct;
    logic [7:0] zin;
    int         idx;
    prevAct = 8'h00;
    // Walk zed in signed order -128..+127 so monotonicity can be checked on the fly.
    for (int c = 0; c < 256 + LAT - 1; c++) begin
      if (c < 256) begin
        zin = 8'(c) ^ 8'h80;
        applyStimulus(1'b1, zin);
      end else begin
        applyStimulus(1'b0, 8'h00);
      end
      tick();
      idx = c - LAT + 1;
      if (idx >= 0) begin
        expAct = refModel(8'(idx) ^ 8'h80);
        checks++;
        if (activation !== expAct || out_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL sweep_%02h: got %0d/%b expected %0d/1", 8'(idx) ^ 8'h80, activation, out_valid, expAct);
        end
        if (idx > 0) begin
          checks++;
          if (activation < prevAct) begin
            errors++;
            $display("[TB] FAIL monotonic_%02h: got %0d after %0d", 8'(idx) ^ 8'h80, activation, prevAct);
          end
        end
        prevAct = activation;
      end
    end
    applyStimulus(1'b0, 8'h00);
    tick();
  endtask

  task automatic test_hold();
    applyStimulus(1'b1, 8'h10);
    tick();
    applyStimulus(1'b0, 8'hF0);
    repeat (LAT - 1) tick();
    checks++;
    if (activation !== 8'd187 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_first: got %0d/%b expected 187/1", activation, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (activation !== 8'd187 || out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_%0d: got %0d/%b expected 187/0", i, activation, out_valid);
      end
    end
  endtask

  task automatic test_latency();
    applyStimulus(1'b1, 8'h20);
    for (int i = 1; i <= LAT + 1; i++) begin
      tick();
      if (i == 1) applyStimulus(1'b0, 8'h00);
      checks++;
      if (i == LAT) begin
        if (activation !== 8'd225 || out_valid !== 1'b1) begin
          errors++; $display("[TB] FAIL latency_at_%0d: got %0d/%b expected 225/1", i, activation, out_valid);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL latency_valid_%0d: got %b expected 0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
